serial_subtractor: RTL and testbench

Parametrised successor to the single-bit half subtractor. Computes A − B − borrow_in over WIDTH bits, CHUNK bits per clock, LSB chunk first, with a ripple borrow held in a register between chunks. Valid/ready handshakes on input and output let it sit in arithmetic datapaths where area matters more than latency. Also reports borrow, signed overflow and zero flags.

---
 rtl/serial_sub_pkg.sv | 17 +
 rtl/chunk_subtractor.sv | 25 ++
 rtl/serial_subtractor.sv | 122 ++++++++++++
 tb/tb_serial_subtractor.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_sub_pkg.sv
// Shared types and helpers for the chunked serial subtractor.
package serial_sub_pkg;

    typedef logic [1:0] state_t;

    localparam state_t IDLE = 2'd0;
    localparam state_t RUN  = 2'd1;
    localparam state_t DONE = 2'd2;

    // Signed overflow of a subtraction: operands of opposite sign and the
    // result's sign differs from the minuend's.
    function automatic logic sub_overflow(input logic a_msb, input logic b_msb,
                                          input logic d_msb);
        return (a_msb != b_msb) && (d_msb != a_msb);
    endfunction

endpackage

// File: rtl/chunk_subtractor.sv
// Combinational CHUNK-bit subtractor: x - y - bin as a ripple of
// full-subtractor cells, with the final borrow on bout.
module chunk_subtractor #(
    parameter int unsigned CHUNK = 4
) (
    input  logic [CHUNK-1:0] x,
    input  logic [CHUNK-1:0] y,
    input  logic             bin,
    output logic [CHUNK-1:0] d,
    output logic             bout
);

    logic [CHUNK:0] br;

    assign br[0] = bin;

    for (genvar i = 0; i < CHUNK; i++) begin : g_cell
        assign d[i]    = x[i] ^ y[i] ^ br[i];
        // Borrow when x[i] < y[i] + br[i]
        assign br[i+1] = (~x[i] & (y[i] | br[i])) | (y[i] & br[i]);
    end

    assign bout = br[CHUNK];

endmodule

// File: rtl/serial_subtractor.sv
// Serial subtractor: a - b - borrow_in over WIDTH bits, CHUNK bits per
// clock, LSB chunk first, with valid/ready handshakes on both sides.
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             borrow_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] difference,
    output logic             borrow_out,
    output logic             overflow,
    output logic             zero
);

    localparam int unsigned NCHUNK = WIDTH / CHUNK;
    localparam int unsigned CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);

    if (WIDTH < 2) begin : g_width_check
        $fatal(1, "serial_subtractor: WIDTH must be at least 2");
    end
    if (WIDTH % CHUNK != 0) begin : g_chunk_check
        $fatal(1, "serial_subtractor: WIDTH must be a multiple of CHUNK");
    end

    state_t           state_q;
    logic [CW-1:0]    idx_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             borrow_q;
    logic [WIDTH-1:0] diff_q;
    logic             borrow_out_q;
    logic             overflow_q;
    logic             zero_q;

    logic [CHUNK-1:0] x_chunk;
    logic [CHUNK-1:0] y_chunk;
    logic [CHUNK-1:0] d_chunk;
    logic             chunk_bout;
    logic [WIDTH-1:0] diff_next;

    chunk_subtractor #(
        .CHUNK (CHUNK)
    ) u_chunk (
        .x    (x_chunk),
        .y    (y_chunk),
        .bin  (borrow_q),
        .d    (d_chunk),
        .bout (chunk_bout)
    );

    // Select the operand chunk for the current index and merge its result
    // into the running difference.
    always_comb begin
        x_chunk   = a_q[int'(idx_q) * CHUNK +: CHUNK];
        y_chunk   = b_q[int'(idx_q) * CHUNK +: CHUNK];
        diff_next = diff_q;
        diff_next[int'(idx_q) * CHUNK +: CHUNK] = d_chunk;
    end

    // FSM, operand latch, ripple borrow and result/flag registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            a_q          <= '0;
            b_q          <= '0;
            borrow_q     <= 1'b0;
            diff_q       <= '0;
            borrow_out_q <= 1'b0;
            overflow_q   <= 1'b0;
            zero_q       <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        a_q      <= a;
                        b_q      <= b;
                        borrow_q <= borrow_in;
                        idx_q    <= '0;
                        state_q  <= RUN;
                    end
                end
                RUN: begin
                    diff_q   <= diff_next;
                    borrow_q <= chunk_bout;
                    idx_q    <= idx_q + CW'(1);
                    if (idx_q == LAST) begin
                        state_q      <= DONE;
                        borrow_out_q <= chunk_bout;
                        overflow_q   <= sub_overflow(a_q[WIDTH-1], b_q[WIDTH-1],
                                                     diff_next[WIDTH-1]);
                        zero_q       <= (diff_next == '0);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready   = (state_q == IDLE);
    assign out_valid  = (state_q == DONE);
    assign difference = diff_q;
    assign borrow_out = borrow_out_q;
    assign overflow   = overflow_q;
    assign zero       = zero_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: directed cases on a CHUNK=4
// instance plus randomized handshake traffic on CHUNK=4, 16 and 1 instances.
module tb_serial_subtractor;

    localparam int W = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                rst_n;
    logic [2:0]          in_valid;
    logic [2:0]          out_ready;
    logic [2:0]          borrow_in;
    logic [2:0][W-1:0]   a;
    logic [2:0][W-1:0]   b;
    logic [2:0]          in_ready;
    logic [2:0]          out_valid;
    logic [2:0]          borrow_out;
    logic [2:0]          overflow;
    logic [2:0]          zero;
    logic [2:0][W-1:0]   difference;

    int tests = 0;
    int fails = 0;

    serial_subtractor #(.WIDTH(W), .CHUNK(4)) u_c4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .a(a[0]), .b(b[0]), .borrow_in(borrow_in[0]), .out_valid(out_valid[0]),
        .out_ready(out_ready[0]), .difference(difference[0]), .borrow_out(borrow_out[0]),
        .overflow(overflow[0]), .zero(zero[0])
    );

    serial_subtractor #(.WIDTH(W), .CHUNK(16)) u_c16 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .a(a[1]), .b(b[1]), .borrow_in(borrow_in[1]), .out_valid(out_valid[1]),
        .out_ready(out_ready[1]), .difference(difference[1]), .borrow_out(borrow_out[1]),
        .overflow(overflow[1]), .zero(zero[1])
    );

    serial_subtractor #(.WIDTH(W), .CHUNK(1)) u_c1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
        .a(a[2]), .b(b[2]), .borrow_in(borrow_in[2]), .out_valid(out_valid[2]),
        .out_ready(out_ready[2]), .difference(difference[2]), .borrow_out(borrow_out[2]),
        .overflow(overflow[2]), .zero(zero[2])
    );

    function automatic int nchunk(input int k);
        return (k == 0) ? 4 : ((k == 1) ? 1 : 16);
    endfunction

    // Reference: plain integer arithmetic on the operand values.
    function automatic void model(input logic [W-1:0] av, input logic [W-1:0] bv,
                                  input logic bi, output logic [W-1:0] d,
                                  output logic bo, output logic ov, output logic z);
        int r;
        r  = int'(av) - int'(bv) - int'(bi);
        bo = (r < 0);
        d  = r[W-1:0];
        ov = (av[W-1] != bv[W-1]) && (d[W-1] != av[W-1]);
        z  = (d == '0);
    endfunction

    // Present operands at a negedge while idle; scramble them after acceptance.
    task automatic start_op(input int k, input logic [W-1:0] av, input logic [W-1:0] bv,
                            input logic bi);
        a[k] = av;
        b[k] = bv;
        borrow_in[k] = bi;
        in_valid[k] = 1'b1;
        @(negedge clk);
        in_valid[k] = 1'b0;
        a[k] = W'($urandom);
        b[k] = W'($urandom);
        borrow_in[k] = 1'($urandom);
    endtask

    task automatic wait_done(input int k, output int lat);
        lat = 0;
        while (out_valid[k] !== 1'b1 && lat < 200) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic finish_op(input int k);
        out_ready[k] = 1'b1;
        @(negedge clk);
        out_ready[k] = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            tests++;
            if (in_ready[k] !== 1'b1 || out_valid[k] !== 1'b0 || difference[k] !== '0 ||
                borrow_out[k] !== 1'b0 || overflow[k] !== 1'b0 || zero[k] !== 1'b0) begin
                fails++;
                $display("FAIL reset_state[%0d]: got rdy=%b vld=%b d=%h bo=%b ov=%b z=%b want 1 0 0000 0 0 0",
                         k, in_ready[k], out_valid[k], difference[k], borrow_out[k],
                         overflow[k], zero[k]);
            end
        end
        rst_n = 1'b1;
        @(negedge clk);
        tests++;
        if (in_ready !== 3'b111) begin
            fails++;
            $display("FAIL reset_release_ready: got %b want 111", in_ready);
        end
    endtask

    // Runs a small table of directed vectors on the CHUNK=4 instance.
    task automatic test_directed(input string name, input int n,
                                 input logic [W-1:0] ta[4], input logic [W-1:0] tb[4],
                                 input logic tbi[4], input logic [W-1:0] td[4],
                                 input logic tbo[4], input logic tov[4], input logic tz[4]);
        int lat;
        for (int i = 0; i < n; i++) begin
            start_op(0, ta[i], tb[i], tbi[i]);
            wait_done(0, lat);
            tests++;
            if (lat !== 4) begin
                fails++;
                $display("FAIL %s[%0d] latency: got %0d want 4", name, i, lat);
            end
            tests++;
            if (difference[0] !== td[i]) begin
                fails++;
                $display("FAIL %s[%0d] difference: got %h want %h", name, i, difference[0], td[i]);
            end
            tests++;
            if (borrow_out[0] !== tbo[i] || overflow[0] !== tov[i] || zero[0] !== tz[i]) begin
                fails++;
                $display("FAIL %s[%0d] flags bo/ov/z: got %b%b%b want %b%b%b", name, i,
                         borrow_out[0], overflow[0], zero[0], tbo[i], tov[i], tz[i]);
            end
            finish_op(0);
            tests++;
            if (out_valid[0] !== 1'b0 || in_ready[0] !== 1'b1 || difference[0] !== td[i]) begin
                fails++;
                $display("FAIL %s[%0d] after handshake vld/rdy/d: got %b %b %h want 0 1 %h",
                         name, i, out_valid[0], in_ready[0], difference[0], td[i]);
            end
        end
    endtask

    task automatic test_basic_vectors();
        logic [W-1:0] ta[4], tb[4], td[4];
        logic tbi[4], tbo[4], tov[4], tz[4];
        ta = '{16'h1234, 16'h0000, 16'h8000, 16'h0005};
        tb = '{16'h0234, 16'h0001, 16'h0001, 16'h0005};
        tbi = '{1'b0, 1'b0, 1'b0, 1'b1};
        td = '{16'h1000, 16'hFFFF, 16'h7FFF, 16'hFFFF};
        tbo = '{1'b0, 1'b1, 1'b0, 1'b1};
        tov = '{1'b0, 1'b0, 1'b1, 1'b0};
        tz = '{1'b0, 1'b0, 1'b0, 1'b0};
        test_directed("basic", 4, ta, tb, tbi, td, tbo, tov, tz);
    endtask

    task automatic test_zero();
        logic [W-1:0] ta[4], tb[4], td[4];
        logic tbi[4], tbo[4], tov[4], tz[4];
        ta = '{16'hABCD, 16'h7FFF, 16'h0000, 16'h0000};
        tb = '{16'hABCD, 16'h8000, 16'h0000, 16'h0000};
        tbi = '{1'b0, 1'b0, 1'b0, 1'b0};
        td = '{16'h0000, 16'hFFFF, 16'h0000, 16'h0000};
        tbo = '{1'b0, 1'b1, 1'b0, 1'b0};
        tov = '{1'b0, 1'b1, 1'b0, 1'b0};
        tz = '{1'b1, 1'b0, 1'b1, 1'b0};
        test_directed("zero", 2, ta, tb, tbi, td, tbo, tov, tz);
    endtask

    task automatic test_backpressure();
        int lat;
        start_op(0, 16'h4321, 16'h0321, 1'b0);
        wait_done(0, lat);
        for (int i = 0; i < 3; i++) begin
            a[0] = W'($urandom);
            in_valid[0] = 1'b1;
            @(negedge clk);
            tests++;
            if (out_valid[0] !== 1'b1 || in_ready[0] !== 1'b0 || difference[0] !== 16'h4000) begin
                fails++;
                $display("FAIL backpressure_hold[%0d] vld/rdy/d: got %b %b %h want 1 0 4000",
                         i, out_valid[0], in_ready[0], difference[0]);
            end
        end
        in_valid[0] = 1'b0;
        finish_op(0);
        tests++;
        if (out_valid[0] !== 1'b0 || in_ready[0] !== 1'b1 || difference[0] !== 16'h4000) begin
            fails++;
            $display("FAIL backpressure_release vld/rdy/d: got %b %b %h want 0 1 4000",
                     out_valid[0], in_ready[0], difference[0]);
        end
        start_op(0, 16'h0100, 16'h0001, 1'b0);
        tests++;
        if (in_ready[0] !== 1'b0) begin
            fails++;
            $display("FAIL backpressure_accept in_ready: got %b want 0", in_ready[0]);
        end
        wait_done(0, lat);
        tests++;
        if (lat !== 4 || difference[0] !== 16'h00FF) begin
            fails++;
            $display("FAIL backpressure_next lat/d: got %0d %h want 4 00ff", lat, difference[0]);
        end
        finish_op(0);
    endtask

    task automatic test_reset_mid_run();
        int lat;
        start_op(0, 16'hFFFF, 16'h0001, 1'b0);  // now in 1st RUN cycle
        @(negedge clk);                         // 2nd RUN cycle
        rst_n = 1'b0;
        @(negedge clk);
        tests++;
        if (in_ready[0] !== 1'b1 || out_valid[0] !== 1'b0 || difference[0] !== '0 ||
            borrow_out[0] !== 1'b0 || overflow[0] !== 1'b0 || zero[0] !== 1'b0) begin
            fails++;
            $display("FAIL reset_mid_run rdy/vld/d/bo/ov/z: got %b %b %h %b %b %b want 1 0 0000 0 0 0",
                     in_ready[0], out_valid[0], difference[0], borrow_out[0], overflow[0], zero[0]);
        end
        rst_n = 1'b1;
        @(negedge clk);
        tests++;
        if (out_valid[0] !== 1'b0) begin
            fails++;
            $display("FAIL reset_mid_run_no_result out_valid: got %b want 0", out_valid[0]);
        end
        start_op(0, 16'h0010, 16'h0001, 1'b0);
        wait_done(0, lat);
        tests++;
        if (lat !== 4 || difference[0] !== 16'h000F || borrow_out[0] !== 1'b0) begin
            fails++;
            $display("FAIL reset_mid_run_fresh lat/d/bo: got %0d %h %b want 4 000f 0",
                     lat, difference[0], borrow_out[0]);
        end
        finish_op(0);
    endtask

    task automatic test_back_to_back(input int k, input int n);
        logic [W-1:0] av, bv, ed;
        logic bi, ebo, eov, ez;
        int lat, gap;
        for (int i = 0; i < n; i++) begin
            gap = $urandom_range(0, 2);
            repeat (gap) @(negedge clk);
            tests++;
            if (in_ready[k] !== 1'b1) begin
                fails++;
                $display("FAIL rand[%0d] tx %0d in_ready: got %b want 1", k, i, in_ready[k]);
            end
            av = W'($urandom);
            bv = W'($urandom);
            if ($urandom_range(0, 7) == 0) bv = av;
            bi = 1'($urandom);
            model(av, bv, bi, ed, ebo, eov, ez);
            start_op(k, av, bv, bi);
            wait_done(k, lat);
            tests++;
            if (lat !== nchunk(k)) begin
                fails++;
                $display("FAIL rand[%0d] tx %0d latency: got %0d want %0d", k, i, lat, nchunk(k));
            end
            tests++;
            if (difference[k] !== ed) begin
                fails++;
                $display("FAIL rand[%0d] tx %0d difference %h-%h-%b: got %h want %h",
                         k, i, av, bv, bi, difference[k], ed);
            end
            tests++;
            if (borrow_out[k] !== ebo || overflow[k] !== eov || zero[k] !== ez) begin
                fails++;
                $display("FAIL rand[%0d] tx %0d flags bo/ov/z %h-%h-%b: got %b%b%b want %b%b%b",
                         k, i, av, bv, bi, borrow_out[k], overflow[k], zero[k], ebo, eov, ez);
            end
            gap = $urandom_range(0, 2);
            for (int j = 0; j < gap; j++) begin
                @(negedge clk);
                tests++;
                if (out_valid[k] !== 1'b1 || difference[k] !== ed) begin
                    fails++;
                    $display("FAIL rand[%0d] tx %0d stall vld/d: got %b %h want 1 %h",
                             k, i, out_valid[k], difference[k], ed);
                end
            end
            finish_op(k);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        in_valid = '0;
        out_ready = '0;
        borrow_in = '0;
        a = '0;
        b = '0;
        test_reset();
        test_basic_vectors();
        test_zero();
        test_backpressure();
        test_reset_mid_run();
        test_back_to_back(0, 1000);
        test_back_to_back(1, 1000);
        test_back_to_back(2, 1000);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
